// File: rtl/xnor_match_accum_if.sv
// Purpose : serial match-bit stream in, per-frame match results out.
// Latency : results and done strobe appear 1 clk after the frame's last accepted bit.
// Backpr. : none; the producer's bits are consumed whenever in_valid is high.
// Optional: MATCH_THRESH_EN adds the out_pass result signal.
interface xnor_match_accum_if #(
   parameter int CNT_W = 4
);
   logic             in_valid;
   logic             in_bit;
   logic             in_clear;
   logic [CNT_W-1:0] out_count;
   logic             out_all_equal;
   logic             out_done;
   logic             out_busy;
`ifdef MATCH_THRESH_EN
   logic             out_pass;
`endif

   // Producer side: drives the bit stream, observes frame results.
   modport master (
      output in_valid, in_bit, in_clear,
      input  out_count, out_all_equal, out_done, out_busy
`ifdef MATCH_THRESH_EN
      , input out_pass
`endif
   );

   // Accumulator side: consumes the bit stream, drives frame results.
   modport slave (
      input  in_valid, in_bit, in_clear,
      output out_count, out_all_equal, out_done, out_busy
`ifdef MATCH_THRESH_EN
      , output out_pass
`endif
   );
endinterface

// File: rtl/xnor_match_accum.sv
// Purpose : counts XNOR match bits over fixed FRAME_LEN-bit frames; reports count/all-equal.
// Latency : 1 clk from the last accepted bit to out_done and updated results.
// Backpr. : none; every in_valid bit is taken, bubbles simply hold state (no timeout).
// Optional: MATCH_THRESH_EN adds out_pass = (frame count >= THRESH).
module xnor_match_accum #(
   parameter int FRAME_LEN = 8,
   parameter int CNT_W     = 4,
   parameter int THRESH    = 6
) (
   input  logic                clk,
   input  logic                rst_n,
   xnor_match_accum_if.slave   bus
);

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   localparam logic [CNT_W-1:0] FRAME_LEN_C = CNT_W'(FRAME_LEN);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] bit_idx_q, bit_idx_d;
   logic [CNT_W-1:0] match_acc_q, match_acc_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             all_eq_q, all_eq_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;

   // Running totals including the current bit; a new frame starts from zero.
   logic [CNT_W-1:0] base_idx, base_acc;
   logic [CNT_W-1:0] sum_idx, sum_acc;

`ifdef MATCH_THRESH_EN
   localparam int unsigned THRESH_U = THRESH;
   logic pass_q, pass_d;
`endif

   // Next-state, accumulator and result computation.
   always_comb begin
      state_d     = state_q;
      bit_idx_d   = bit_idx_q;
      match_acc_d = match_acc_q;
      count_d     = count_q;
      all_eq_d    = all_eq_q;
      done_d      = 1'b0;
`ifdef MATCH_THRESH_EN
      pass_d      = pass_q;
`endif
      base_idx = (state_q == ACCUM) ? bit_idx_q   : '0;
      base_acc = (state_q == ACCUM) ? match_acc_q : '0;
      sum_idx  = base_idx + CNT_W'(1);
      sum_acc  = base_acc + CNT_W'(bus.in_bit);

      if (bus.in_clear) begin
         // Abort: drop the partial frame and this cycle's bit, keep last results.
         state_d     = IDLE;
         bit_idx_d   = '0;
         match_acc_d = '0;
      end else if (bus.in_valid) begin
         if (sum_idx == FRAME_LEN_C) begin
            // Frame complete (also covers FRAME_LEN == 1 from IDLE/DONE).
            state_d     = DONE;
            bit_idx_d   = '0;
            match_acc_d = '0;
            count_d     = sum_acc;
            all_eq_d    = (sum_acc == FRAME_LEN_C);
            done_d      = 1'b1;
`ifdef MATCH_THRESH_EN
            pass_d      = (32'(sum_acc) >= THRESH_U);
`endif
         end else begin
            state_d     = ACCUM;
            bit_idx_d   = sum_idx;
            match_acc_d = sum_acc;
         end
      end else if (state_q != ACCUM) begin
         // Nothing in flight: settle in IDLE. In ACCUM a bubble holds everything.
         state_d = IDLE;
      end

      busy_d = (state_d == ACCUM);
   end

   // State and result registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         bit_idx_q   <= '0;
         match_acc_q <= '0;
         count_q     <= '0;
         all_eq_q    <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
`ifdef MATCH_THRESH_EN
         pass_q      <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         bit_idx_q   <= bit_idx_d;
         match_acc_q <= match_acc_d;
         count_q     <= count_d;
         all_eq_q    <= all_eq_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
`ifdef MATCH_THRESH_EN
         pass_q      <= pass_d;
`endif
      end
   end

   assign bus.out_count     = count_q;
   assign bus.out_all_equal = all_eq_q;
   assign bus.out_done      = done_q;
   assign bus.out_busy      = busy_q;
`ifdef MATCH_THRESH_EN
   assign bus.out_pass      = pass_q;
`endif

endmodule

// File: tb/tb_xnor_match_accum.sv
// Directed bench for xnor_match_accum (FRAME_LEN=8, CNT_W=4, THRESH=6).
// Each cycle task drives inputs 1 time unit after a rising edge and samples 1 unit after the next.
module tb_xnor_match_accum;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   xnor_match_accum_if #(.CNT_W(4)) bus_if ();

   xnor_match_accum #(.FRAME_LEN(8), .CNT_W(4), .THRESH(6)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock cycle with the given inputs; returns 1 unit after the edge that took them.
   task automatic cyc(input logic v, input logic b, input logic c);
      bus_if.in_valid = v;
      bus_if.in_bit   = b;
      bus_if.in_clear = c;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] pat;
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      bus_if.in_valid = 1'b0;
      bus_if.in_bit   = 1'b0;
      bus_if.in_clear = 1'b0;
      #3;
      check("rst_count", 32'(bus_if.out_count), 0);
      check("rst_all_eq", 32'(bus_if.out_all_equal), 0);
      check("rst_done", 32'(bus_if.out_done), 0);
      check("rst_busy", 32'(bus_if.out_busy), 0);
`ifdef MATCH_THRESH_EN
      check("rst_pass", 32'(bus_if.out_pass), 0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 1: eight matches
      for (int i = 0; i < 8; i++) begin
         cyc(1'b1, 1'b1, 1'b0);
         if (i == 0) check("t1_busy_first", 32'(bus_if.out_busy), 1);
         if (i == 6) check("t1_no_early_done", 32'(bus_if.out_done), 0);
      end
      check("t1_done", 32'(bus_if.out_done), 1);
      check("t1_count", 32'(bus_if.out_count), 8);
      check("t1_all_eq", 32'(bus_if.out_all_equal), 1);
      check("t1_busy_at_done", 32'(bus_if.out_busy), 0);
      cyc(1'b0, 1'b0, 1'b0);
      check("t1_done_one_cycle", 32'(bus_if.out_done), 0);
      check("t1_count_hold", 32'(bus_if.out_count), 8);

      // 2: 1,0,1,1,0,1,1,1 -> 6 matches
      pat = 8'b1110_1101; // bit i is the i-th bit sent
      for (int i = 0; i < 8; i++) cyc(1'b1, pat[i], 1'b0);
      check("t2_done", 32'(bus_if.out_done), 1);
      check("t2_count", 32'(bus_if.out_count), 6);
      check("t2_all_eq", 32'(bus_if.out_all_equal), 0);
`ifdef MATCH_THRESH_EN
      check("t2_pass6", 32'(bus_if.out_pass), 1);
`endif
      // 1,0,1,0,0,1,1,1 -> 5 matches, back-to-back from DONE
      pat = 8'b1110_0101;
      for (int i = 0; i < 8; i++) cyc(1'b1, pat[i], 1'b0);
      check("t2b_done", 32'(bus_if.out_done), 1);
      check("t2b_count", 32'(bus_if.out_count), 5);
`ifdef MATCH_THRESH_EN
      check("t2b_pass5", 32'(bus_if.out_pass), 0);
`endif
      cyc(1'b0, 1'b0, 1'b0);

      // 3: pattern of test 2 with a bubble after every accepted bit
      pat = 8'b1110_1101;
      for (int i = 0; i < 8; i++) begin
         cyc(1'b1, pat[i], 1'b0);
         if (i < 7) begin
            check($sformatf("t3_busy_bit%0d", i), 32'(bus_if.out_busy), 1);
            cyc(1'b0, 1'b0, 1'b0);
            check($sformatf("t3_busy_gap%0d", i), 32'(bus_if.out_busy), 1);
            check($sformatf("t3_nodone_gap%0d", i), 32'(bus_if.out_done), 0);
         end
      end
      check("t3_done", 32'(bus_if.out_done), 1);
      check("t3_count", 32'(bus_if.out_count), 6);
      cyc(1'b0, 1'b0, 1'b0);
      check("t3_single_done", 32'(bus_if.out_done), 0);

      // 4: 4 bits, then clear with a valid bit present
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, 1'b1);
      check("t4_clear_nodone", 32'(bus_if.out_done), 0);
      check("t4_clear_busy", 32'(bus_if.out_busy), 0);
      check("t4_clear_count", 32'(bus_if.out_count), 6);
      for (int i = 0; i < 8; i++) begin
         cyc(1'b1, 1'b1, 1'b0);
         if (i == 6) check("t4_fresh_frame", 32'(bus_if.out_done), 0);
      end
      check("t4_done", 32'(bus_if.out_done), 1);
      check("t4_count", 32'(bus_if.out_count), 8);
      cyc(1'b0, 1'b0, 1'b0);

      // 5: asynchronous reset mid-frame
      for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0);
      check("t5_busy_before", 32'(bus_if.out_busy), 1);
      bus_if.in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("t5_async_count", 32'(bus_if.out_count), 0);
      check("t5_async_all_eq", 32'(bus_if.out_all_equal), 0);
      check("t5_async_busy", 32'(bus_if.out_busy), 0);
      check("t5_async_done", 32'(bus_if.out_done), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("t5_no_done_after_rst", 32'(bus_if.out_done), 0);
      pat = 8'b0000_0111;
      for (int i = 0; i < 8; i++) cyc(1'b1, pat[i], 1'b0);
      check("t5_done", 32'(bus_if.out_done), 1);
      check("t5_count", 32'(bus_if.out_count), 3);
      check("t5_all_eq", 32'(bus_if.out_all_equal), 0);
      cyc(1'b0, 1'b0, 1'b0);

      // 6: 16 consecutive bits, eight 1s then eight 0s
      for (int i = 0; i < 16; i++) begin
         cyc(1'b1, (i < 8) ? 1'b1 : 1'b0, 1'b0);
         if (i == 7) begin
            check("t6_done1", 32'(bus_if.out_done), 1);
            check("t6_count1", 32'(bus_if.out_count), 8);
            check("t6_all_eq1", 32'(bus_if.out_all_equal), 1);
         end
         if (i == 8) begin
            check("t6_gap_nodone", 32'(bus_if.out_done), 0);
            check("t6_b2b_busy", 32'(bus_if.out_busy), 1);
            check("t6_count_hold", 32'(bus_if.out_count), 8);
         end
      end
      check("t6_done2", 32'(bus_if.out_done), 1);
      check("t6_count2", 32'(bus_if.out_count), 0);
      check("t6_all_eq2", 32'(bus_if.out_all_equal), 0);
      cyc(1'b0, 1'b0, 1'b0);
      check("t6_idle_busy", 32'(bus_if.out_busy), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
